// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU opcode and RV32I encoding constants, the decoded-bundle struct,
// and the funct3-to-ALU-op mapping. The ALU consumes this same package.
package alu_decode_stage_pkg;

    localparam logic [7:0] ALU_NOP  = 8'h0;
    localparam logic [7:0] ALU_ADD  = 8'h1;
    localparam logic [7:0] ALU_SUB  = 8'h2;
    localparam logic [7:0] ALU_SLL  = 8'h3;
    localparam logic [7:0] ALU_SLT  = 8'h4;
    localparam logic [7:0] ALU_SLTU = 8'h5;
    localparam logic [7:0] ALU_XOR  = 8'h6;
    localparam logic [7:0] ALU_SRL  = 8'h7;
    localparam logic [7:0] ALU_SRA  = 8'h8;
    localparam logic [7:0] ALU_OR   = 8'h9;
    localparam logic [7:0] ALU_AND  = 8'ha;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [7:0]  alu_op;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [4:0]  rd;
        logic        rd_we;
    } dec_t;

    // alt selects sub over add and sra over srl
    function automatic logic [7:0] alu_op_of(input logic [2:0] f3, input logic alt);
        logic [7:0] op;
        op = ALU_NOP;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP / OP-IMM / LUI decode into an ALU bundle.
// Unsupported encodings collapse to a nop with illegal raised.
module alu_op_decode
    import alu_decode_stage_pkg::*;
#(
    parameter int ZERO_RD_WE = 0
) (
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output dec_t        dec,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_shift;
    logic       legal;
    logic       unused_rs1_field;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
    // rs1 index is resolved by the register file before this stage
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        dec       = '0;
        dec.rd    = instr[11:7];
        legal     = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                dec.alu_op = alu_op_of(f3, f7 == F7_ALT);
                dec.alu_a  = rs1_val;
                // ALU shifts by the full operand, so trim the shamt here
                dec.alu_b  = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
                else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                  legal = 1'b1;
                dec.alu_op = alu_op_of(f3, (f3 == F3_SR) && (f7 == F7_ALT));
                dec.alu_a  = rs1_val;
                dec.alu_b  = is_shift ? {27'b0, instr[24:20]}
                                      : {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LUI: begin
                legal      = 1'b1;
                dec.alu_op = ALU_ADD;
                dec.alu_a  = '0;
                dec.alu_b  = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.rd_we = (ZERO_RD_WE != 0) || (dec.rd != 5'd0);
        end else begin
            dec.alu_op = ALU_NOP;
            dec.alu_a  = '0;
            dec.alu_b  = '0;
            dec.rd_we  = 1'b0;
        end
        illegal = !legal;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: alu_op_decode feeding a one-entry valid/ready output register.
// Define ALU_DECODE_ILLEGAL_EN to add the registered illegal output.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int ZERO_RD_WE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  rd,
`ifdef ALU_DECODE_ILLEGAL_EN
    output logic        illegal,
`endif
    output logic        rd_we
);

    dec_t dec;
    dec_t q;
    logic dec_illegal;
    logic load;

    alu_op_decode #(.ZERO_RD_WE(ZERO_RD_WE)) u_dec (
        .instr   (instr),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .dec     (dec),
        .illegal (dec_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    // flush kills both the held bundle and any load in the same cycle
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (load)      out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (load) q <= dec;
        end
    end

`ifdef ALU_DECODE_ILLEGAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    illegal <= 1'b0;
        else if (load) illegal <= dec_illegal;
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    assign alu_op = q.alu_op;
    assign alu_a  = q.alu_a;
    assign alu_b  = q.alu_b;
    assign rd     = q.rd;
    assign rd_we  = q.rd_we;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage; honours ALU_DECODE_ILLEGAL_EN if defined.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, rd_we;
    logic [31:0] instr, rs1_val, rs2_val, alu_a, alu_b;
    logic [7:0]  alu_op;
    logic [4:0]  rd;
`ifdef ALU_DECODE_ILLEGAL_EN
    logic        illegal;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .rd        (rd),
`ifdef ALU_DECODE_ILLEGAL_EN
        .illegal   (illegal),
`endif
        .rd_we     (rd_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_val  = a;
        rs2_val  = b;
    endtask

    task automatic chk_bundle(input string tag, input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] r, input logic we);
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_op"},  {24'b0, alu_op}, {24'b0, op});
        chk({tag, "_a"},   alu_a, a);
        chk({tag, "_b"},   alu_b, b);
        chk({tag, "_rd"},  {27'b0, rd}, {27'b0, r});
        chk({tag, "_we"},  {31'b0, rd_we}, {31'b0, we});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; rs1_val = '0; rs2_val = '0;
        #2;
        chk("rst_vld",   {31'b0, out_valid}, 32'd0);
        chk("rst_op",    {24'b0, alu_op}, 32'd0);
        chk("rst_a",     alu_a, 32'd0);
        chk("rst_b",     alu_b, 32'd0);
        chk("rst_we",    {31'b0, rd_we}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // sub x2,x1,x2
        drive(32'h40208133, 32'd5, 32'd7); step();
        chk_bundle("sub", 8'h2, 32'd5, 32'd7, 5'd2, 1'b1);
        // srai x1,x1,4
        drive(32'h4040D093, 32'h80000000, 32'h0); step();
        chk_bundle("srai", 8'h8, 32'h80000000, 32'd4, 5'd1, 1'b1);
        // sll x5,x6,x7 with shamt source 0x21 -> 1
        drive(32'h007312B3, 32'h0000000F, 32'h00000021); step();
        chk_bundle("sll", 8'h3, 32'h0000000F, 32'd1, 5'd5, 1'b1);
        // lui x3,0x12345
        drive(32'h123451B7, 32'hDEADBEEF, 32'h0); step();
        chk_bundle("lui", 8'h1, 32'h0, 32'h12345000, 5'd3, 1'b1);
        // addi x4,x0,-1: sign extension
        drive(32'hFFF00213, 32'd10, 32'h0); step();
        chk_bundle("addi", 8'h1, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b1);
        // add x0,x0,x0: rd==0 suppresses rd_we by default
        drive(32'h00000033, 32'd3, 32'd4); step();
        chk_bundle("add_x0", 8'h1, 32'd3, 32'd4, 5'd0, 1'b0);
        // lw x1,0(x0): unsupported opcode
        drive(32'h00002083, 32'd9, 32'd9); step();
        chk("ld_op", {24'b0, alu_op}, 32'd0);
        chk("ld_b",  alu_b, 32'd0);
        chk("ld_we", {31'b0, rd_we}, 32'd0);
`ifdef ALU_DECODE_ILLEGAL_EN
        chk("ld_ill", {31'b0, illegal}, 32'd1);
`endif
        // OP funct7=0100000 with funct3=001: unsupported
        drive(32'h401090B3, 32'd1, 32'd1); step();
        chk("alt_sll_op", {24'b0, alu_op}, 32'd0);
        chk("alt_sll_we", {31'b0, rd_we}, 32'd0);

        // stall sequence: out_ready 1,0,0,1
        drive(32'h003140B3, 32'h111, 32'h0); out_ready = 1'b1; step();
        chk_bundle("xor", 8'h6, 32'h111, 32'h0, 5'd1, 1'b1);
        drive(32'h003160B3, 32'h222, 32'h0); out_ready = 1'b0; #1;
        chk("stall_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk_bundle("stall1", 8'h6, 32'h111, 32'h0, 5'd1, 1'b1);
        chk("stall1_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk_bundle("stall2", 8'h6, 32'h111, 32'h0, 5'd1, 1'b1);
        out_ready = 1'b1; step();
        chk_bundle("or", 8'h9, 32'h222, 32'h0, 5'd1, 1'b1);
        in_valid = 1'b0; step();
        chk("drain_vld", {31'b0, out_valid}, 32'd0);

        // flush into an empty stage blocks the load
        drive(32'h40208133, 32'd5, 32'd7); flush = 1'b1; step();
        chk("flush_empty_vld", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; step();
        chk("post_flush_vld", {31'b0, out_valid}, 32'd1);
        // flush while stalled clears the held bundle
        out_ready = 1'b0; flush = 1'b1; step();
        chk("flush_stall_vld", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;

        // reset mid-stall: outputs clear before the next edge
        drive(32'h123451B7, 32'h0, 32'h0); step();
        step();
        chk("pre_rst_vld", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0; #1;
        chk("arst_vld", {31'b0, out_valid}, 32'd0);
        chk("arst_op",  {24'b0, alu_op}, 32'd0);
        chk("arst_b",   alu_b, 32'd0);
        chk("arst_rd",  {27'b0, rd}, 32'd0);
        chk("arst_we",  {31'b0, rd_we}, 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_vld", {31'b0, out_valid}, 32'd0);
        drive(32'h40208133, 32'd5, 32'd7); step();
        chk_bundle("post_rst_sub", 8'h2, 32'd5, 32'd7, 5'd2, 1'b1);
        in_valid = 1'b0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter: ZERO_RD_WE, default 0, meaning: if 0, rd_we is forced to 0 when rd == 0.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline kill.
REQ-005 in_valid  input  1  instruction/operands present.
REQ-006 in_ready  output  1  stage accepts input this cycle.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 rs1_val, rs2_val  input  32 each  register-file read data.
REQ-009 out_valid  output  1  decoded bundle present.
REQ-010 out_ready  input  1  downstream ALU stage accepts bundle.
REQ-011 alu_op  output  8  ALU opcode (8'h0 nop, 8'h1..8'ha as in REQ-016).
REQ-012 alu_a, alu_b  output  32 each  ALU operands.
REQ-013 rd  output  5  destination register; rd_we  output  1  write enable.
REQ-014 illegal  output  1  unsupported instruction (present only with ALU_DECODE_ILLEGAL_EN).

Function
REQ-015 Decoding: opcode 0110011 = OP (register-register), 0010011 = OP-IMM, 0110111 = LUI; any other opcode is unsupported.
REQ-016 alu_op map by funct3:
- 000: add 1, or sub 2 when OP and funct7 = 0100000.
- 001: sll 3; 010: slt 4; 011: sltu 5; 100: xor 6.
- 101: srl 7 with funct7 0000000, sra 8 with funct7 0100000.
- 110: or 9; 111: and a.
REQ-017 OP: alu_a = rs1_val; alu_b = rs2_val, except for shifts, where alu_b = {27'b0, rs2_val[4:0]}, because the ALU shifts by the full operand.
REQ-018 OP-IMM: alu_a = rs1_val; alu_b = sign-extended instr[31:20]; for shifts, alu_b = {27'b0, instr[24:20]}.
REQ-019 LUI: alu_op = 1, alu_a = 0, alu_b = {instr[31:12], 12'b0}.
REQ-020 Unsupported encodings are any other opcode, OP funct7 not in {0000000, 0100000}, 0100000 with funct3 not in {000, 101}, and OP-IMM shift funct7 violations; each yields alu_op = 0, alu_b = 0, rd_we = 0.
REQ-021 Output register behaviour:
- One-entry output register; latency 1 cycle from accepted input to out_valid.
- in_ready = !out_valid || out_ready (combinational).
- Transfer occurs when in_valid && in_ready; the register loads and out_valid = 1 next cycle.
REQ-022 While out_valid && !out_ready, all outputs hold stable regardless of inputs.
REQ-023 out_valid && out_ready without a new transfer clears out_valid next cycle.
REQ-024 Simultaneous drain and accept keeps out_valid = 1 with new contents (full throughput).
REQ-025 flush = 1 clears out_valid next cycle and blocks any load that cycle; flush wins over a simultaneous accept.

Reset
REQ-026 rst_n low asynchronously clears out_valid, alu_op, alu_a, alu_b, rd, rd_we and illegal to 0.
REQ-027 An in-flight bundle is discarded by reset; the first accept after release behaves as from empty.

Configuration
REQ-028 ALU_DECODE_ILLEGAL_EN defined: the illegal port exists, is registered alongside the bundle, and is 1 for REQ-020 encodings.
REQ-029 ALU_DECODE_ILLEGAL_EN undefined: no illegal port; unsupported encodings still decode as nop.

Structure
REQ-030 Shared package: ALU opcode constants (nop, add..and = 8'h0..8'ha) and RV32I opcode/funct3/funct7 constants; the ALU consumes the same package.
REQ-031 One combinational sub-module alu_op_decode (instr to alu_op, operand selects, rd_we, illegal); the top holds the handshake register.

Verification
REQ-032 instr 0x40208133 (sub x2,x1,x2), rs1 = 5, rs2 = 7 -> one cycle later out_valid = 1, alu_op = 2, a = 5, b = 7, rd = 2, rd_we = 1.
REQ-033 srai x1,x1,4 (0x4040D093), rs1 = 0x80000000 -> alu_op = 8, b = 4; sll with rs2 = 0x00000021 -> b = 1.
REQ-034 lui x3,0x12345 -> alu_op = 1, a = 0, b = 0x12345000.
REQ-035 Back-to-back valid with out_ready toggling 1,0,0,1 -> no bundle lost or duplicated, outputs stable during stall, in_ready = 0 while stalled.
REQ-036 Opcode 0000011 (load) -> alu_op = 0, rd_we = 0, illegal = 1 (macro on); flush asserted with in_valid -> out_valid = 0 next cycle.
REQ-037 rst_n pulsed low mid-stall asynchronously -> all outputs 0 before the next clock edge.
